alu_mul_sequencer: RTL and testbench

ALU_MUL_SEQUENCER -- requirements
Module: alu_mul_sequencer

---
 rtl/alu_mul_sequencer_if.sv | 24 ++
 rtl/alu_mul_sequencer.sv | 110 +++++++++++
 tb/tb_alu_mul_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_if.sv
// Handshake and shared-ALU bus for the shift-add multiplier sequencer.
// The slave side is the sequencer; the master side is the requester plus the ALU.
interface alu_mul_sequencer_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic [31:0] alu_in_1;
  logic [31:0] alu_in_2;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;

  modport slave (
    input  start, op_a, op_b, alu_result,
    output ready, done, result, alu_in_1, alu_in_2, alu_op
  );

  modport master (
    output start, op_a, op_b, alu_result,
    input  ready, done, result, alu_in_1, alu_in_2, alu_op
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add 32x32 multiplier (low 32 bits) that borrows an external ALU
// for every add and shift, one ALU operation per cycle.
module alu_mul_sequencer #(
  parameter int EARLY_EXIT = 1
) (
  input logic                 clk,
  input logic                 reset,
  alu_mul_sequencer_if.slave  bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADD  = 3'd1;
  localparam logic [2:0] SHL  = 3'd2;
  localparam logic [2:0] SHR  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SHL  = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1011;
  localparam logic [3:0] OP_NONE = 4'b1111;

  logic [2:0]  state;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] result;
  logic [4:0]  iter;
  logic        last_iter;

  assign bus.ready  = (state == IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = result;

  // The shifted-out multiplier is already on alu_result during SHR, so the
  // exit decision uses it directly instead of waiting a cycle for mplier.
  assign last_iter = (iter == 5'd31) ||
                     ((EARLY_EXIT != 0) && (bus.alu_result == 32'd0));

  always_comb begin
    bus.alu_in_1 = 32'd0;
    bus.alu_in_2 = 32'd0;
    bus.alu_op   = OP_NONE;
    case (state)
      ADD: begin
        bus.alu_in_1 = acc;
        bus.alu_in_2 = mplier[0] ? mcand : 32'd0;
        bus.alu_op   = OP_ADD;
      end
      SHL: begin
        bus.alu_in_1 = mcand;
        bus.alu_op   = OP_SHL;
      end
      SHR: begin
        bus.alu_in_1 = mplier;
        bus.alu_in_2 = 32'd1;
        bus.alu_op   = OP_SHR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= 32'd0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      result <= 32'd0;
      iter   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc    <= 32'd0;
            mcand  <= bus.op_a;
            mplier <= bus.op_b;
            iter   <= 5'd0;
            if (bus.op_b == 32'd0) begin
              result <= 32'd0;
              state  <= DONE;
            end else begin
              state  <= ADD;
            end
          end
        end
        ADD: begin
          acc   <= bus.alu_result;
          state <= SHL;
        end
        SHL: begin
          mcand <= bus.alu_result;
          state <= SHR;
        end
        SHR: begin
          mplier <= bus.alu_result;
          iter   <= iter + 5'd1;
          if (last_iter) begin
            result <= acc;
            state  <= DONE;
          end else begin
            state  <= ADD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer: one early-exit instance and one
// fixed-32-iteration instance, each wired to a behavioural ALU.
module tb_alu_mul_sequencer;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   rdy_due0 = 1'b0;
  bit   rdy_due1 = 1'b0;

  alu_mul_sequencer_if bus0();
  alu_mul_sequencer_if bus1();

  alu_mul_sequencer #(.EARLY_EXIT(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  alu_mul_sequencer #(.EARLY_EXIT(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b1100: return a << 1;
      4'b1011: return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  always_comb bus0.alu_result = alu_ref(bus0.alu_op, bus0.alu_in_1, bus0.alu_in_2);
  always_comb bus1.alu_result = alu_ref(bus1.alu_op, bus1.alu_in_1, bus1.alu_in_2);

  // Iterations needed: one per multiplier bit up to the top set bit.
  function automatic int ref_k(input logic [31:0] b, input bit ee);
    if (b == 32'd0) return 0;
    if (!ee) return 32;
    for (int i = 31; i >= 0; i--) if (b[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitors: pop an expectation whenever a done pulse appears.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (rdy_due0) chk("dut0_ready_after_done", bus0.ready, 1);
      rdy_due0 = 1'b0;
      if (bus0.done) begin
        if (q0.size() == 0) chk("dut0_unexpected_done", bus0.done, 0);
        else begin
          exp_t e;
          e = q0.pop_front();
          chk("dut0_result", bus0.result, e.res);
          chk("dut0_done_cycle", cyc, e.cyc);
          rdy_due0 = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (rdy_due1) chk("dut1_ready_after_done", bus1.ready, 1);
      rdy_due1 = 1'b0;
      if (bus1.done) begin
        if (q1.size() == 0) chk("dut1_unexpected_done", bus1.done, 0);
        else begin
          exp_t e;
          e = q1.pop_front();
          chk("dut1_result", bus1.result, e.res);
          chk("dut1_done_cycle", cyc, e.cyc);
          rdy_due1 = 1'b1;
        end
      end
    end
  end

  // Waits for ready while throwing junk starts at the busy DUT, then issues.
  // Returns at the negedge of the first cycle after acceptance.
  task automatic issue0(input logic [31:0] a, input logic [31:0] b, input bit junk);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!bus0.ready && n < 200) begin
      if (junk) begin
        bus0.start = 1'($urandom_range(0, 1));
        bus0.op_a  = $urandom;
        bus0.op_b  = $urandom;
      end
      @(negedge clk);
      n++;
    end
    if (!bus0.ready) begin
      chk("dut0_ready_timeout", bus0.ready, 1);
      bus0.start = 1'b0;
      return;
    end
    bus0.start = 1'b1;
    bus0.op_a  = a;
    bus0.op_b  = b;
    e.res = ref_prod(a, b);
    e.cyc = cyc + 3 * ref_k(b, 1'b1) + 1;
    q0.push_back(e);
    @(negedge clk);
    bus0.start = 1'b0;
    bus0.op_a  = $urandom;
    bus0.op_b  = $urandom;
  endtask

  task automatic issue1(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!bus1.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus1.ready) begin
      chk("dut1_ready_timeout", bus1.ready, 1);
      return;
    end
    bus1.start = 1'b1;
    bus1.op_a  = a;
    bus1.op_b  = b;
    e.res = ref_prod(a, b);
    e.cyc = cyc + 3 * ref_k(b, 1'b0) + 1;
    q1.push_back(e);
    @(negedge clk);
    bus1.start = 1'b0;
    bus1.op_a  = $urandom;
    bus1.op_b  = $urandom;
  endtask

  task automatic drain;
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q0_empty", q0.size(), 0);
    chk("drain_q1_empty", q1.size(), 0);
  endtask

  initial begin
    logic [3:0] pat [3];
    logic [31:0] a, b;
    pat[0] = 4'b0000; pat[1] = 4'b1100; pat[2] = 4'b1011;
    reset = 1'b1;
    bus0.start = 1'b0; bus0.op_a = 32'd0; bus0.op_b = 32'd0;
    bus1.start = 1'b0; bus1.op_a = 32'd0; bus1.op_b = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ready", bus0.ready, 1);
    chk("reset_done", bus0.done, 0);
    chk("reset_result", bus0.result, 0);
    chk("reset_alu_op", bus0.alu_op, 4'b1111);
    chk("reset_alu_in_1", bus0.alu_in_1, 0);
    chk("reset_ready_dut1", bus1.ready, 1);

    // Directed: 3*5, all-ones squared, zero multiplier.
    issue0(32'd3, 32'd5, 1'b0);
    issue0(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    issue0(32'h1234, 32'd0, 1'b0);
    chk("zero_path_alu_idle", bus0.alu_op, 4'b1111);
    drain();

    // A start mid-operation must be ignored.
    issue0(32'd3, 32'd5, 1'b0);
    repeat (3) @(negedge clk);
    bus0.start = 1'b1; bus0.op_a = 32'd7; bus0.op_b = 32'd7;
    @(negedge clk);
    bus0.start = 1'b0;
    drain();
    repeat (2) @(negedge clk);
    chk("result_held", bus0.result, 15);

    // Reset during an operation aborts it: no done, result cleared.
    issue0(32'd3, 32'd5, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    q0.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", bus0.ready, 1);
    chk("abort_result", bus0.result, 0);
    chk("abort_done", bus0.done, 0);
    repeat (8) @(negedge clk);
    chk("abort_result_later", bus0.result, 0);

    // Randomized back-to-back traffic with junk starts while busy.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      issue0(a, b, 1'b1);
    end
    drain();

    // Fixed-iteration instance: full 32 passes and the ALU op pattern.
    issue1(32'd3, 32'd5);
    for (int i = 0; i < 96; i++) begin
      if (bus1.alu_op !== pat[i % 3]) chk("dut1_alu_op_seq", bus1.alu_op, pat[i % 3]);
      else begin n_chk++; n_pass++; end
      @(negedge clk);
    end
    drain();
    for (int i = 0; i < 3; i++) issue1($urandom, $urandom >> $urandom_range(0, 31));
    issue1(32'h1234, 32'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
